vga_pattern_gen: RTL and testbench

Test-pattern source sitting directly upstream of the VGA timing driver. Consumes the driver's look-ahead pixel request and coordinates (`vga_request`, `vga_xpos`, `vga_ypos`, one clock early) and returns a registered 24-bit RGB pixel on `vga_data` exactly one clock later, aligned with the driver's display enable. Provides four selectable patterns, switched only on frame boundaries; one pattern is a bouncing box animated once per frame.

---
 rtl/vga_pattern_pkg.sv | 41 ++++
 rtl/vga_box_anim.sv | 66 ++++++
 rtl/vga_pattern_gen.sv | 126 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_pkg.sv
// Shared constants and helpers for the VGA test-pattern source.
// Provides pattern mode codes, RGB888 colours and the bar colour lookup.
package vga_pattern_pkg;

   localparam logic [1:0] MODE_BARS  = 2'd0;
   localparam logic [1:0] MODE_RAMP  = 2'd1;
   localparam logic [1:0] MODE_CHECK = 2'd2;
   localparam logic [1:0] MODE_BOX   = 2'd3;

   localparam logic [23:0] C_WHITE   = 24'hffffff;
   localparam logic [23:0] C_YELLOW  = 24'hffff00;
   localparam logic [23:0] C_CYAN    = 24'h00ffff;
   localparam logic [23:0] C_GREEN   = 24'h00ff00;
   localparam logic [23:0] C_MAGENTA = 24'hff00ff;
   localparam logic [23:0] C_RED     = 24'hff0000;
   localparam logic [23:0] C_BLUE    = 24'h0000ff;
   localparam logic [23:0] C_BLACK   = 24'h000000;

   typedef enum logic {
      DIR_INC,
      DIR_DEC
   } dir_t;

   function automatic logic [23:0] bar_colour(
      input logic [2:0] idx
   );
      logic [23:0] c;
      case (idx)
         3'd0:    c = C_WHITE;
         3'd1:    c = C_YELLOW;
         3'd2:    c = C_CYAN;
         3'd3:    c = C_GREEN;
         3'd4:    c = C_MAGENTA;
         3'd5:    c = C_RED;
         3'd6:    c = C_BLUE;
         default: c = C_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_box_anim.sv
// Bouncing box position, stepped once per frame_tick.
// Ports: clk_25m, rst_n, frame_tick in; box_x, box_y (12b) out.
module vga_box_anim #(
   parameter int H_DISP   = 640,
   parameter int V_DISP   = 480,
   parameter int BOX_SIZE = 32
) (
   input  logic        clk_25m,
   input  logic        rst_n,
   input  logic        frame_tick,
   output logic [11:0] box_x,
   output logic [11:0] box_y
);
   import vga_pattern_pkg::*;

   localparam logic [11:0] X_MAX = 12'(H_DISP - BOX_SIZE);
   localparam logic [11:0] Y_MAX = 12'(V_DISP - BOX_SIZE);

   dir_t x_dir;
   dir_t y_dir;

   // At a limit the direction flips and the box already moves back
   // in the same update, so it never sits still for a frame.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         box_x <= '0;
         box_y <= '0;
         x_dir <= DIR_INC;
         y_dir <= DIR_INC;
      end else if (frame_tick) begin
         unique case (x_dir)
            DIR_INC:
               if (box_x == X_MAX) begin
                  x_dir <= DIR_DEC;
                  box_x <= box_x - 12'd1;
               end else begin
                  box_x <= box_x + 12'd1;
               end
            DIR_DEC:
               if (box_x == 12'd0) begin
                  x_dir <= DIR_INC;
                  box_x <= box_x + 12'd1;
               end else begin
                  box_x <= box_x - 12'd1;
               end
         endcase
         unique case (y_dir)
            DIR_INC:
               if (box_y == Y_MAX) begin
                  y_dir <= DIR_DEC;
                  box_y <= box_y - 12'd1;
               end else begin
                  box_y <= box_y + 12'd1;
               end
            DIR_DEC:
               if (box_y == 12'd0) begin
                  y_dir <= DIR_INC;
                  box_y <= box_y + 12'd1;
               end else begin
                  box_y <= box_y - 12'd1;
               end
         endcase
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern source feeding the VGA timing driver; registered RGB888
// one clock after the look-ahead request. Optional macro:
// VGA_AUTO_CYCLE_EN (advance pattern every AUTO_FRAMES frames).
// Ports: clk_25m, rst_n, vga_request, vga_xpos, vga_ypos, mode_next in;
//        vga_data (24b), mode (2b), frame_tick out.
module vga_pattern_gen #(
   parameter int H_DISP      = 640,
   parameter int V_DISP      = 480,
   parameter int BOX_SIZE    = 32,
   parameter int AUTO_FRAMES = 120
) (
   input  logic        clk_25m,
   input  logic        rst_n,
   input  logic        vga_request,
   input  logic [11:0] vga_xpos,
   input  logic [11:0] vga_ypos,
   input  logic        mode_next,
   output logic [23:0] vga_data,
   output logic [1:0]  mode,
   output logic        frame_tick
);
   import vga_pattern_pkg::*;

   localparam logic [11:0] X_LAST = 12'(H_DISP - 1);
   localparam logic [11:0] Y_LAST = 12'(V_DISP - 1);
   localparam logic [11:0] BAR_W  = 12'(H_DISP / 8);
   localparam logic [11:0] BOX_W  = 12'(BOX_SIZE);

   logic        pending;
   logic        frame_end;
   logic        manual;
   logic        adv;
   logic [11:0] box_x;
   logic [11:0] box_y;
   logic [11:0] bar_q;
   logic [2:0]  bar_idx;
   logic        in_box;
   logic [23:0] pix;

   assign frame_end = vga_request
                    && (vga_xpos == X_LAST)
                    && (vga_ypos == Y_LAST);

   assign manual = pending | mode_next;

`ifdef VGA_AUTO_CYCLE_EN
   localparam int CW = $clog2(AUTO_FRAMES + 1);

   logic [CW-1:0] auto_cnt;
   logic          auto_hit;

   assign auto_hit = (auto_cnt == CW'(AUTO_FRAMES - 1));
   assign adv      = frame_tick & (manual | auto_hit);

   // Any advance, manual or automatic, restarts the frame count.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         auto_cnt <= '0;
      end else if (frame_tick) begin
         if (adv) auto_cnt <= '0;
         else     auto_cnt <= auto_cnt + 1'b1;
      end
   end
`else
   logic unused_auto;
   assign unused_auto = ^AUTO_FRAMES;
   assign adv         = frame_tick & manual;
`endif

   // Requests are latched and only honoured on the frame_tick cycle
   // so the pattern never changes mid-frame.
   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) begin
         mode       <= MODE_BARS;
         pending    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (adv) mode <= mode + 2'd1;
         if (frame_tick)     pending <= 1'b0;
         else if (mode_next) pending <= 1'b1;
      end
   end

   vga_box_anim #(
      .H_DISP   (H_DISP),
      .V_DISP   (V_DISP),
      .BOX_SIZE (BOX_SIZE)
   ) u_box (
      .clk_25m    (clk_25m),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .box_x      (box_x),
      .box_y      (box_y)
   );

   assign bar_q   = vga_xpos / BAR_W;
   assign bar_idx = (bar_q > 12'd7) ? 3'd7 : bar_q[2:0];

   assign in_box = (vga_xpos >= box_x)
                && (vga_xpos <  box_x + BOX_W)
                && (vga_ypos >= box_y)
                && (vga_ypos <  box_y + BOX_W);

   always_comb begin
      pix = C_BLACK;
      unique case (1'b1)
         (mode == MODE_BARS):
            pix = bar_colour(bar_idx);
         (mode == MODE_RAMP):
            pix = {3{vga_xpos[9:2]}};
         (mode == MODE_CHECK):
            pix = (vga_xpos[5] ^ vga_ypos[5]) ? C_WHITE : C_BLACK;
         (mode == MODE_BOX):
            pix = in_box ? C_RED : C_BLUE;
         default:
            pix = C_BLACK;
      endcase
   end

   always_ff @(posedge clk_25m or negedge rst_n) begin
      if (!rst_n) vga_data <= C_BLACK;
      else        vga_data <= vga_request ? pix : C_BLACK;
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen against a frame-level model.
// Frames are shortened to sparse pixel requests ending on the last pixel.
module tb_vga_pattern_gen;

   localparam int HD = 640;
   localparam int VD = 480;
   localparam int BS = 32;

   logic        clk_25m = 1'b0;
   logic        rst_n;
   logic        vga_request;
   logic [11:0] vga_xpos;
   logic [11:0] vga_ypos;
   logic        mode_next;
   logic [23:0] vga_data;
   logic [1:0]  mode;
   logic        frame_tick;

   int n_vec = 0;
   int n_err = 0;

   int m_mode;
   int m_frames;
   bit m_pend;
   bit m_tick;

   always #20 clk_25m = ~clk_25m;

   vga_pattern_gen #(
      .H_DISP      (HD),
      .V_DISP      (VD),
      .BOX_SIZE    (BS),
      .AUTO_FRAMES (120)
   ) dut (
      .clk_25m     (clk_25m),
      .rst_n       (rst_n),
      .vga_request (vga_request),
      .vga_xpos    (vga_xpos),
      .vga_ypos    (vga_ypos),
      .mode_next   (mode_next),
      .vga_data    (vga_data),
      .mode        (mode),
      .frame_tick  (frame_tick)
   );

   task automatic check(
      input string       tag,
      input logic [23:0] got,
      input logic [23:0] exp
   );
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, got, exp);
      end
   endtask

   // Triangle wave: position after n steps bouncing on 0..mx.
   function automatic int tri_pos(input int n, input int mx);
      int t;
      t = n % (2 * mx);
      return (t <= mx) ? t : (2 * mx - t);
   endfunction

   function automatic logic [23:0] ref_pix(
      input int md, input int fr, input int x, input int y
   );
      int idx, g, bx, by;
      logic [23:0] c;
      c = 24'h0;
      case (md)
         0: begin
            idx = x / (HD / 8);
            if (idx > 7) idx = 7;
            case (idx)
               0: c = 24'hffffff;
               1: c = 24'hffff00;
               2: c = 24'h00ffff;
               3: c = 24'h00ff00;
               4: c = 24'hff00ff;
               5: c = 24'hff0000;
               6: c = 24'h0000ff;
               default: c = 24'h000000;
            endcase
         end
         1: begin
            g = (x / 4) % 256;
            c = {g[7:0], g[7:0], g[7:0]};
         end
         2: c = (((x / 32) ^ (y / 32)) % 2 == 1) ? 24'hffffff : 24'h0;
         default: begin
            bx = tri_pos(fr, HD - BS);
            by = tri_pos(fr, VD - BS);
            if (x >= bx && x < bx + BS && y >= by && y < by + BS)
               c = 24'hff0000;
            else
               c = 24'h0000ff;
         end
      endcase
      return c;
   endfunction

   task automatic cyc(input bit req, input int x, input int y,
                      input bit mn);
      logic [23:0] exp_d;
      bit          exp_t;
      exp_d = req ? ref_pix(m_mode, m_frames, x, y) : 24'h0;
      exp_t = req && (x == HD - 1) && (y == VD - 1);
      vga_request = req;
      vga_xpos    = x[11:0];
      vga_ypos    = y[11:0];
      mode_next   = mn;
      @(posedge clk_25m);
      #1;
      if (m_tick) begin
         if (m_pend || mn) m_mode = (m_mode + 1) % 4;
         m_pend = 1'b0;
         m_frames++;
      end else if (mn) begin
         m_pend = 1'b1;
      end
      m_tick = exp_t;
      check("data", vga_data, exp_d);
      check("tick", {23'h0, frame_tick}, {23'h0, exp_t});
      check("mode", {22'h0, mode}, 24'(m_mode));
      vga_request = 1'b0;
      mode_next   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      vga_request = 1'b0;
      mode_next   = 1'b0;
      vga_xpos    = '0;
      vga_ypos    = '0;
      #3;
      check("rst_data", vga_data, 24'h0);
      check("rst_mode", {22'h0, mode}, 24'h0);
      check("rst_tick", {23'h0, frame_tick}, 24'h0);
      m_mode   = 0;
      m_frames = 0;
      m_pend   = 1'b0;
      m_tick   = 1'b0;
      @(posedge clk_25m);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic end_frame(input bit mn_on_tick);
      cyc(1'b1, HD - 1, VD - 1, 1'b0);
      cyc(1'b0, 0, 0, mn_on_tick);
   endtask

   task automatic rnd_pix(input int n);
      for (int i = 0; i < n; i++)
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 799),
             $urandom_range(0, VD - 1), 1'b0);
   endtask

   task automatic box_probe();
      int bx, by;
      bx = tri_pos(m_frames, HD - BS);
      by = tri_pos(m_frames, VD - BS);
      cyc(1'b1, bx, by, 1'b0);
      cyc(1'b1, bx + BS - 1, by + BS - 1, 1'b0);
      cyc(1'b1, bx + BS, by, 1'b0);
      cyc(1'b1, bx, by + BS, 1'b0);
      if (bx > 0) cyc(1'b1, bx - 1, by, 1'b0);
      if (by > 0) cyc(1'b1, bx, by - 1, 1'b0);
   endtask

   initial begin
      do_reset();

      cyc(1'b1, 0, 10, 1'b0);
      cyc(1'b1, 80, 10, 1'b0);
      check("bar1", vga_data, 24'hffff00);

      for (int i = 0; i < 800; i++)
         cyc(1'b0, $urandom_range(0, 799), $urandom_range(0, 524), 1'b0);
      cyc(1'b0, HD - 1, VD - 1, 1'b0);
      cyc(1'b0, 0, 0, 1'b0);

      rnd_pix(100);

      cyc(1'b1, 100, 100, 1'b1);
      rnd_pix(20);
      end_frame(1'b0);
      cyc(1'b1, 400, 7, 1'b0);
      check("ramp400", vga_data, 24'h646464);

      for (int f = 0; f < 8; f++) begin
         rnd_pix(40);
         if ($urandom_range(0, 1) == 1) begin
            cyc(1'b1, $urandom_range(0, 639), 3, 1'b1);
            rnd_pix(3);
            cyc(1'b1, $urandom_range(0, 639), 4, 1'b1);
         end
         end_frame($urandom_range(0, 2) == 0);
      end

      for (int k = 0; k < 4 && m_mode != 3; k++) begin
         cyc(1'b1, 5, 5, 1'b1);
         end_frame(1'b0);
      end

      for (int f = 0; f < 620; f++) begin
         box_probe();
         rnd_pix(3);
         end_frame(1'b0);
      end

      end_frame(1'b1);
      cyc(1'b1, 0, 0, 1'b0);
      check("wrap0", {22'h0, mode}, 24'h0);

      cyc(1'b1, 3, 3, 1'b1);
      rnd_pix(5);
      do_reset();
      end_frame(1'b0);
      cyc(1'b1, 80, 0, 1'b0);
      check("post_rst", vga_data, 24'hffff00);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
